stopwatch_mmss_counter: RTL and testbench

//   Downstream consumer of the 1 Hz divider square wave. Detects each rising edge of

---
 rtl/stopwatch_mmss_counter.sv | 152 +++++++++++++++
 tb/tb_stopwatch_mmss_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mmss_counter.sv
// BCD MM:SS stopwatch counting rising edges of a 1 Hz tick under start/stop/clear.
// Optional latched alarm compare enabled by defining STOPWATCH_ALARM_EN.
module stopwatch_mmss_counter #(
  parameter int         MAX_MIN_TENS = 5,
  parameter logic [7:0] ALARM_MIN    = 8'h01,
  parameter logic [7:0] ALARM_SEC    = 8'h30
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       rollover,
  output logic       alarm
);

  localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_e;

  state_e     state_q, state_d;
  logic       tick_d_q;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       running_q, running_d;
  logic       rollover_q, rollover_d;
  logic       sec_tick;
  logic       do_inc;
  logic       so_max, st_max, mo_max, mt_max;

  always_comb begin
    sec_tick = tick_in & ~tick_d_q;
    do_inc   = sec_tick & (state_q == S_RUN) & ~clear;
    so_max   = (sec_ones_q == 4'd9);
    st_max   = (sec_tens_q == 4'd5);
    mo_max   = (min_ones_q == 4'd9);
    mt_max   = (min_tens_q == MT_MAX);
  end

  // Priority: clear, then start_stop, then tick; a RUN tick
  // coinciding with start_stop still counts before pausing.
  always_comb begin
    state_d    = state_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    rollover_d = 1'b0;
    if (clear) begin
      state_d    = S_IDLE;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else begin
      if (do_inc) begin
        sec_ones_d = so_max ? 4'd0 : sec_ones_q + 4'd1;
        if (so_max) begin
          sec_tens_d = st_max ? 4'd0 : sec_tens_q + 4'd1;
          if (st_max) begin
            min_ones_d = mo_max ? 4'd0 : min_ones_q + 4'd1;
            if (mo_max) begin
              min_tens_d = mt_max ? 4'd0 : min_tens_q + 4'd1;
              rollover_d = mt_max;
            end
          end
        end
      end
      if (start_stop) begin
        unique case (state_q)
          S_IDLE:  state_d = S_RUN;
          S_RUN:   state_d = S_PAUSE;
          S_PAUSE: state_d = S_RUN;
          default: state_d = S_IDLE;
        endcase
      end
    end
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tick_d_q   <= 1'b0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      running_q  <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_d_q   <= tick_in;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
      rollover_q <= rollover_d;
    end
  end

`ifdef STOPWATCH_ALARM_EN
  // inc_q marks the cycle whose displayed digits came from an increment.
  logic inc_q, inc_d;
  logic alarm_q, alarm_d;
  logic hit;

  always_comb begin
    inc_d   = do_inc;
    hit     = ({min_tens_q, min_ones_q} == ALARM_MIN) &&
              ({sec_tens_q, sec_ones_q} == ALARM_SEC);
    alarm_d = alarm_q | (inc_q & hit);
    if (clear) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      inc_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      inc_q   <= inc_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
  assign running  = running_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_mmss_counter.sv
// Bench for stopwatch_mmss_counter: seconds-count model checked every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_stopwatch_mmss_counter;

  localparam int LIMIT = 3600;
`ifdef STOPWATCH_ALARM_EN
  localparam int ALARM_ON = 1;
`else
  localparam int ALARM_ON = 0;
`endif

  logic       Clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, rollover, alarm;

  int total = 0;
  int bad = 0;
  int roll_cnt = 0;

  stopwatch_mmss_counter dut (
    .Clk(Clk), .reset_n(reset_n), .tick_in(tick_in),
    .start_stop(start_stop), .clear(clear),
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .rollover(rollover), .alarm(alarm)
  );

  always #5 Clk = ~Clk;

  // Model: elapsed seconds as one integer, mode 0 idle / 1 run / 2 pause.
  int m_secs = 0;
  int m_mode = 0;
  logic m_prev = 1'b0;
  logic m_roll = 1'b0;
  logic m_pend = 1'b0;
  logic m_alarm = 1'b0;

  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      m_secs <= 0; m_mode <= 0; m_prev <= 1'b0;
      m_roll <= 1'b0; m_pend <= 1'b0; m_alarm <= 1'b0;
    end else begin
      m_prev <= tick_in;
      m_roll <= 1'b0;
      m_pend <= 1'b0;
      if (clear) begin
        m_secs <= 0; m_mode <= 0; m_alarm <= 1'b0;
      end else begin
        if (tick_in && !m_prev && m_mode == 1) begin
          m_secs <= (m_secs + 1) % LIMIT;
          m_roll <= (m_secs + 1 == LIMIT);
          m_pend <= ((m_secs + 1) % LIMIT == 90) && (ALARM_ON == 1);
        end
        m_alarm <= m_alarm | m_pend;
        if (start_stop) m_mode <= (m_mode == 1) ? 2 : 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int mmss();
    return min_tens * 1000 + min_ones * 100 + sec_tens * 10 + sec_ones;
  endfunction

  always @(negedge Clk) begin
    chk("model_digits", mmss(), (m_secs / 60) * 100 + m_secs % 60);
    chk("model_running", running, m_mode == 1);
    chk("model_rollover", rollover, m_roll);
    chk("model_alarm", alarm, m_alarm);
    if (rollover) roll_cnt <= roll_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic tick(input int h, input int l, input int n);
    repeat (n) begin
      tick_in = 1'b1; cyc(h);
      tick_in = 1'b0; cyc(l);
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; cyc(1); start_stop = 1'b0; cyc(1);
  endtask

  task automatic pulse_clr();
    clear = 1'b1; cyc(1); clear = 1'b0; cyc(1);
  endtask

  int r0;

  initial begin
    cyc(3);
    reset_n = 1'b1;
    cyc(2);
    chk("reset_digits", mmss(), 0);
    chk("reset_running", running, 0);

    // Reset mid-count
    pulse_ss();
    tick(2, 2, 7);
    chk("pre_reset_0007", mmss(), 7);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_digits", mmss(), 0);
    chk("async_reset_running", running, 0);
    @(posedge Clk); #1 reset_n = 1'b1;
    tick(2, 2, 2);
    chk("idle_after_reset", mmss(), 0);
    chk("idle_running", running, 0);

    // 12 ticks then one long-high tick
    pulse_ss();
    tick(4, 4, 12);
    chk("count_0012", mmss(), 12);
    chk("count_running", running, 1);
    tick(20, 4, 1);
    chk("long_high_once", mmss(), 13);

    // start_stop coincident with tick
    pulse_clr();
    pulse_ss();
    tick(2, 2, 3);
    chk("pre_pause_0003", mmss(), 3);
    tick_in = 1'b1; start_stop = 1'b1; cyc(1);
    start_stop = 1'b0; cyc(1);
    tick_in = 1'b0; cyc(2);
    chk("pause_counted_0004", mmss(), 4);
    chk("pause_running", running, 0);
    tick(2, 2, 3);
    chk("pause_ignores", mmss(), 4);
    pulse_ss();
    chk("resume_running", running, 1);
    tick(2, 2, 1);
    chk("resume_0005", mmss(), 5);

    // clear coincident with tick
    pulse_clr();
    pulse_ss();
    tick(2, 2, 9);
    chk("pre_clear_0009", mmss(), 9);
    tick_in = 1'b1; clear = 1'b1; cyc(1);
    clear = 1'b0; cyc(1);
    tick_in = 1'b0; cyc(1);
    chk("clear_tick_digits", mmss(), 0);
    chk("clear_tick_running", running, 0);

    // Alarm at 01:30, then wrap from 59:59
    pulse_clr();
    pulse_ss();
    tick(1, 1, 90);
    chk("alarm_0130", mmss(), 130);
    chk("alarm_set", alarm, ALARM_ON);
    tick(1, 1, 3500);
    chk("preset_5950", mmss(), 5950);
    r0 = roll_cnt;
    tick(1, 1, 10);
    chk("wrap_digits", mmss(), 0);
    chk("wrap_pulses", roll_cnt - r0, 1);
    chk("wrap_running", running, 1);
    chk("alarm_holds_wrap", alarm, ALARM_ON);
    pulse_clr();
    chk("alarm_cleared", alarm, 0);

    // Random stimulus against the model
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 3) == 0) tick_in = ~tick_in;
      start_stop = ($urandom_range(0, 15) == 0);
      clear = ($urandom_range(0, 80) == 0);
      reset_n = ($urandom_range(0, 1499) != 0);
      cyc(1);
    end
    reset_n = 1'b1;
    start_stop = 1'b0;
    clear = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
